// File: rtl/sap_program_loader.sv
// ---------------------------------------------------------------------------
// sap_program_loader
//
// Write side of the SAP 16x8 program RAM. A framed byte stream
//   header H, N = H[3:0]+1 data bytes, checksum C
// is received over a valid/ready handshake. The data bytes are written to RAM
// from address 0 upward. A good checksum fills the remaining words with FILL
// and then releases the processor. A bad checksum parks in an error state with
// the processor still held in reset.
//
// Handshake: a byte on DATA_IN is transferred on a rising CLK edge when
// VALID && READY are both high. READY is decoded only from the state register
// and never looks at VALID. A source seeing VALID && !READY must hold its byte.
//
// Ports
//   CLK       in   clock, rising edge
//   CLR       in   asynchronous active-high reset
//   START     in   one-cycle load request (honoured in IDLE, DONE, ERR)
//   DATA_IN   in   stream byte
//   VALID     in   DATA_IN valid
//   READY     out  loader accepts DATA_IN this cycle (HDR, DATA, CHK)
//   WE        out  registered RAM write strobe
//   WR_ADDR   out  registered RAM write address
//   WR_DATA   out  registered RAM write data
//   CPU_CLR   out  high while the processor must stay in reset
//   DONE      out  load finished with a good checksum
//   ERR       out  checksum mismatch
//   dbg_state out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module sap_program_loader #(
  parameter int                WIDTH1 = 4,
  parameter int                WIDTH2 = 8,
  parameter int                DEPTH  = 16,
  parameter logic [WIDTH2-1:0] FILL   = 8'hF0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [WIDTH2-1:0] DATA_IN,
  input  logic              VALID,
  output logic              READY,
  output logic              WE,
  output logic [WIDTH1-1:0] WR_ADDR,
  output logic [WIDTH2-1:0] WR_DATA,
  output logic              CPU_CLR,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [WIDTH1-1:0] LAST = WIDTH1'(DEPTH - 1);
  localparam logic [WIDTH1-1:0] ONE  = WIDTH1'(1);

  state_t            state, state_n;
  logic [WIDTH1-1:0] cnt, cnt_n;          // data bytes still to come, minus one
  logic [WIDTH1-1:0] addr, addr_n;        // next RAM address to write
  logic [WIDTH2-1:0] sum, sum_n;          // running mod-256 data sum
  logic              full, full_n;        // frame carries DEPTH data bytes
  logic              fill_end, fill_end_n;// address DEPTH-1 has been written
  logic              we_q, we_n;
  logic [WIDTH1-1:0] wr_addr_q, wr_addr_n;
  logic [WIDTH2-1:0] wr_data_q, wr_data_n;

  logic              accept;
  logic [WIDTH2-1:0] chk_sum;

  // READY is a pure decode of the registered state.
  assign READY     = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  assign accept    = VALID && READY;
  assign chk_sum   = sum + DATA_IN;

  assign WE        = we_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign DONE      = (state == S_DONE);
  assign ERR       = (state == S_ERR);
  assign CPU_CLR   = (state != S_DONE);
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      sum       <= '0;
      full      <= 1'b0;
      fill_end  <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      sum       <= sum_n;
      full      <= full_n;
      fill_end  <= fill_end_n;
      we_q      <= we_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr;
    sum_n      = sum;
    full_n     = full;
    fill_end_n = fill_end;
    we_n       = 1'b0;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;

    case (state)
      S_IDLE: begin
        if (START) state_n = S_HDR;
      end

      S_HDR: begin
        if (accept) begin
          cnt_n   = DATA_IN[WIDTH1-1:0];
          full_n  = (DATA_IN[WIDTH1-1:0] == LAST);
          addr_n  = '0;
          sum_n   = '0;
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          we_n      = 1'b1;
          wr_addr_n = addr;
          wr_data_n = DATA_IN;
          sum_n     = chk_sum;
          addr_n    = addr + ONE;
          if (cnt == '0) state_n = S_CHK;
          else           cnt_n   = cnt - ONE;
        end
      end

      S_CHK: begin
        if (accept) begin
          if (chk_sum == '0) begin
            if (full) begin
              state_n = S_DONE;
            end else begin
              // The first fill word is issued on the checksum edge so the
              // fill burst starts the cycle right after C is accepted.
              we_n       = 1'b1;
              wr_addr_n  = addr;
              wr_data_n  = FILL;
              addr_n     = addr + ONE;
              fill_end_n = (addr == LAST);
              state_n    = S_FILL;
            end
          end else begin
            state_n = S_ERR;
          end
        end
      end

      S_FILL: begin
        // One idle edge after the last fill word, so DONE appears the cycle
        // after the final write is visible.
        if (fill_end) begin
          state_n = S_DONE;
        end else begin
          we_n       = 1'b1;
          wr_addr_n  = addr;
          wr_data_n  = FILL;
          addr_n     = addr + ONE;
          fill_end_n = (addr == LAST);
        end
      end

      S_DONE, S_ERR: begin
        if (START) state_n = S_HDR;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sap_program_loader.sv
// ---------------------------------------------------------------------------
// tb_sap_program_loader
//
// Drives framed loads into sap_program_loader and checks every RAM write,
// its cycle, and the final DONE/ERR/CPU_CLR status against a frame-level
// model: the expected write list is data bytes at 0..N-1, followed on a good
// checksum by FILL words at N..15. Fill words land in consecutive cycles
// starting the cycle after C is accepted; DONE follows the last write.
// ---------------------------------------------------------------------------
module tb_sap_program_loader;

  localparam int         DEPTH = 16;
  localparam logic [7:0] FILLV = 8'hF0;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       START;
  logic [7:0] DATA_IN;
  logic       VALID;
  logic       READY;
  logic       WE;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       CPU_CLR;
  logic       DONE;
  logic       ERR;
  logic [2:0] dbg_state;

  sap_program_loader dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .START     (START),
    .DATA_IN   (DATA_IN),
    .VALID     (VALID),
    .READY     (READY),
    .WE        (WE),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .CPU_CLR   (CPU_CLR),
    .DONE      (DONE),
    .ERR       (ERR),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard state
  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q[$];
  int          acc_cyc[16];
  int          c_cyc;
  int          n_cur;
  int          n_exp;
  int          wr_idx;
  int          done_cyc;
  int          err_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe outputs once per cycle, away from the active edge.
  task automatic sample();
    logic [11:0] e;
    if (WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_count_over", wr_idx + 1, n_exp);
      end else begin
        e = exp_q.pop_front();
        check("wr", {20'd0, WR_ADDR, WR_DATA}, {20'd0, e});
        if (wr_idx < n_cur) check("wr_cyc", cyc, acc_cyc[wr_idx]);
        else                check("fill_cyc", cyc, c_cyc + wr_idx - n_cur);
      end
      wr_idx++;
    end
    if (DONE === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (ERR  === 1'b1 && err_cyc  < 0) err_cyc  = cyc;
  endtask

  task automatic step();
    @(negedge CLK);
    sample();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},   READY,     0);
    check({tag, "_we"},      WE,        0);
    check({tag, "_addr"},    WR_ADDR,   0);
    check({tag, "_data"},    WR_DATA,   0);
    check({tag, "_cpu_clr"}, CPU_CLR,   1);
    check({tag, "_done"},    DONE,      0);
    check({tag, "_err"},     ERR,       0);
    check({tag, "_state"},   dbg_state, 0);
  endtask

  // mode: 0 = VALID always high, 1 = VALID pattern 1,0,0,..., 2 = random
  // VALID plus random START while the frame is streaming.
  // abort_at >= 0: pulse CLR right after that data byte index is accepted.
  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] d[16],
                           input logic [7:0] c, input int mode, input int abort_at);
    int         n;
    int         sum;
    bit         pass;
    logic [7:0] b[18];
    int         nb;
    int         phase;
    int         waits;
    bit         accepted;
    bit         v;

    // reference model
    n    = int'(hdr[3:0]) + 1;
    sum  = 0;
    for (int i = 0; i < n; i++) sum += int'(d[i]);
    pass = ((sum + int'(c)) % 256) == 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({i[3:0], d[i]});
    if (pass) for (int a = n; a < DEPTH; a++) exp_q.push_back({a[3:0], FILLV});
    n_exp    = exp_q.size();
    n_cur    = n;
    wr_idx   = 0;
    done_cyc = -1;
    err_cyc  = -1;
    c_cyc    = -1;

    START = 1'b1;
    step();
    START = 1'b0;
    check("start_done",    DONE,    0);
    check("start_err",     ERR,     0);
    check("start_cpu_clr", CPU_CLR, 1);
    check("start_ready",   READY,   1);

    b[0] = hdr;
    for (int i = 0; i < n; i++) b[i + 1] = d[i];
    b[n + 1] = c;
    nb    = n + 2;
    phase = 0;

    for (int k = 0; k < nb; k++) begin
      waits    = 0;
      accepted = 1'b0;
      while (!accepted) begin
        case (mode)
          1:       v = (phase % 3) == 0;
          2:       v = 1'($urandom_range(0, 1));
          default: v = 1'b1;
        endcase
        phase++;
        VALID   = v;
        DATA_IN = v ? b[k] : 8'($urandom);
        START   = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (READY && VALID) begin
          accepted = 1'b1;
          if (k >= 1 && k <= n) acc_cyc[k - 1] = cyc + 1;
          if (k == nb - 1)      c_cyc = cyc + 1;
        end
        step();
        if (!accepted) begin
          waits++;
          if (waits > 40) begin
            check("accept_timeout", waits, 0);
            VALID = 1'b0;
            START = 1'b0;
            return;
          end
        end
      end
      if (abort_at >= 0 && k == abort_at + 1) begin
        VALID = 1'b0;
        START = 1'b0;
        CLR   = 1'b1;
        #1;
        check_reset("abort");
        check("abort_writes", wr_idx, abort_at + 1);
        step();
        CLR = 1'b0;
        exp_q.delete();
        n_exp = 0;
        step();
        return;
      end
    end

    VALID = 1'b0;
    START = 1'b0;
    for (int t = 0; t < 24; t++) step();

    check("wr_count", wr_idx, n_exp);
    check("ready_end", READY, 0);
    if (pass) begin
      check("done",     DONE,     1);
      check("err",      ERR,      0);
      check("cpu_clr",  CPU_CLR,  0);
      check("done_cyc", done_cyc, c_cyc + DEPTH - n);
    end else begin
      check("err",      ERR,      1);
      check("done",     DONE,     0);
      check("cpu_clr",  CPU_CLR,  1);
      check("err_cyc",  err_cyc,  c_cyc);
    end
  endtask

  initial begin
    logic [7:0] dn[16];
    logic [7:0] df[16];
    logic [7:0] dr[16];
    logic [7:0] hr;
    logic [7:0] cr;
    int         sr;

    CLR     = 1'b1;
    START   = 1'b0;
    VALID   = 1'b0;
    DATA_IN = 8'h00;
    n_cur   = 0;
    n_exp   = 0;
    wr_idx  = 0;
    c_cyc   = -1;
    done_cyc = -1;
    err_cyc  = -1;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    CLR = 1'b0;
    step();
    check_reset("idle");

    for (int i = 0; i < 16; i++) begin
      dn[i] = 8'h00;
      df[i] = 8'(i);
    end
    dn[0] = 8'h09;
    dn[1] = 8'h1A;
    dn[2] = 8'hE0;

    run_frame(8'h02, dn, 8'hFD, 0, -1);   // normal load
    run_frame(8'h02, dn, 8'hFE, 0, -1);   // bad checksum
    run_frame(8'h0F, df, 8'h88, 0, -1);   // full program, no fill
    run_frame(8'h02, dn, 8'hFD, 1, -1);   // stalled source
    run_frame(8'hA2, dn, 8'hFD, 0, -1);   // restart from DONE, header high bits ignored
    run_frame(8'h02, dn, 8'hFD, 0, 1);    // CLR after second data byte
    run_frame(8'h02, dn, 8'hFD, 0, -1);   // clean load after the abort

    for (int r = 0; r < 24; r++) begin
      hr = 8'($urandom);
      sr = 0;
      for (int i = 0; i < 16; i++) begin
        dr[i] = 8'($urandom);
        if (i <= int'(hr[3:0])) sr += int'(dr[i]);
      end
      cr = 8'(256 - (sr % 256));
      if ($urandom_range(0, 3) == 0) cr = cr ^ 8'($urandom_range(1, 255));
      run_frame(hr, dr, cr, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_program_loader.md
# sap_program_loader

Byte-stream program loader for the SAP processor: the write side of the 16x8 program RAM that the processor only ever reads. It accepts a framed byte stream over a valid/ready handshake and writes the program into RAM sequentially. It fills unused words, checks a checksum, and holds the processor in reset (CPU_CLR) until a load completes successfully.

## Interface
- WIDTH1, 4: RAM address width.
- WIDTH2, 8: data / byte width.
- DEPTH, 16: RAM words; equals 2**WIDTH1.
- FILL, 8'hF0: value written to words beyond the loaded program (HLT).

- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request to begin a load.
- DATA_IN  input  WIDTH2  stream byte.
- VALID  input  1  DATA_IN valid.
- READY  output  1  loader accepts DATA_IN this cycle.
- WE  output  1  RAM write strobe.
- WR_ADDR  output  WIDTH1  RAM write address.
- WR_DATA  output  WIDTH2  RAM write data.
- CPU_CLR  output  1  processor reset hold; high = processor held in reset.
- DONE  output  1  load completed with a good checksum.
- ERR  output  1  checksum mismatch.

## Operation
- Frame format: header byte H, then N = H[3:0]+1 data bytes (1..16), then checksum byte C. Header bits [7:4] are ignored.
- Transfer: a byte is accepted on a rising edge with VALID && READY. VALID without READY is ignored; the source holds its byte.
- States:
  - IDLE: READY=0. START goes to HDR; it also clears DONE and ERR and sets CPU_CLR=1.
  - HDR: READY=1. The accepted byte latches N-1 into a down-counter and clears the address and sum registers. Go to DATA.
  - DATA: READY=1. Each accepted byte is written to the current address, added into the 8-bit sum (mod 256), and the address increments. After the Nth byte, go to CHK.
  - CHK: READY=1. Accepted C passes if (sum + C) mod 256 == 0. Pass: go to FILL, or to DONE if N == DEPTH. Fail: go to ERR.
  - FILL: READY=0. Writes FILL to addresses N..DEPTH-1, one per cycle, then goes to DONE.
  - DONE: DONE=1, CPU_CLR=0. START restarts (goes to HDR).
  - ERR: ERR=1, CPU_CLR=1. RAM is left partially written; no fill is done. START restarts.
- START is ignored in HDR, DATA, CHK and FILL.
- The address register is WIDTH1 bits wide. No wrap can occur, since N ≤ DEPTH and FILL stops at DEPTH-1.
- Header and checksum bytes are never written to RAM.

## Timing
- Reset values: state IDLE, READY=0, WE=0, WR_ADDR=0, WR_DATA=0, CPU_CLR=1, DONE=0, ERR=0, sum=0, address=0.
- CLR asserted mid-load aborts immediately to the reset values. A write pending for that edge is dropped.
- Write latency: WE, WR_ADDR and WR_DATA are registered and appear one cycle after the accepting edge. WE is high for exactly one cycle per written byte.
- READY is a registered function of state only and never depends on VALID in the same cycle.
- Back-to-back bytes: with VALID held high, one byte is accepted per cycle. READY stays high from HDR entry through C acceptance.
- FILL: WE is high for DEPTH-N consecutive cycles, starting the cycle after C is accepted.
- DONE and CPU_CLR=0 take effect in the cycle after the last fill write. If N == DEPTH, they take effect the cycle after C is accepted. ERR takes effect the cycle after C is accepted.
- START asserted in the same cycle as an accepted byte: the byte is processed and START is ignored.

## Test plan
- Normal load: H=8'h02, data 09,1A,E0, C=8'hFD. Required: writes (0,09),(1,1A),(2,E0), then FILL F0 to addresses 3..15 over 13 consecutive cycles, then DONE=1 and CPU_CLR=0.
- Bad checksum: same frame with C=8'hFE. Required: 3 writes only, ERR=1, CPU_CLR=1, DONE=0, no FILL writes.
- Full program: H=8'h0F, 16 bytes 00..0F (sum 8'h78), C=8'h88. Required: 16 writes to addresses 0..15, no FILL, DONE the cycle after C is accepted.
- Stalled source: normal load frame with VALID toggled 1,0,0,1... Required: write sequence identical to the normal load; no byte is duplicated or lost.
- Reset mid-load: CLR pulsed after the second data byte is accepted. Required: all outputs return to reset values immediately. A subsequent START plus a valid frame loads correctly.
- Restart from DONE: START issued in DONE. Required: DONE clears and CPU_CLR returns to 1 the next cycle, then the second frame loads normally.
